alu_serial_ctrl: RTL

//  Bit-serial ALU sequencer: the driving end of the 1-bit ALU slice interface (a, b, sm, sa, sb, c_in, op -> result, c_out).

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_slice_decode.sv | 57 +++++
 rtl/alu_serial_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared codes for the bit-serial ALU sequencer: operation codes, slice op codes,
// sequencer states and the supported-operation check used at acceptance.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SOP_AND = 2'b00;
    localparam logic [1:0] SOP_OR  = 2'b01;
    localparam logic [1:0] SOP_SUM = 2'b10;
    localparam logic [1:0] SOP_SM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SET  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic ctl_supported(input logic [3:0] ctl);
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_slice_decode.sv
// Maps the latched ALU operation and current bit index onto the 1-bit slice
// controls: operand inversions, slice op and carry-in source.
module alu_slice_decode
    import alu_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [3:0]       ctl,
    input  logic [IDX_W-1:0] idx,
    output logic             sa,
    output logic             sb,
    output logic [1:0]       op,
    output logic             cin_from_carry,
    output logic             cin_first,
    output logic             is_arith,
    output logic             is_slt
);

    // Bit 0 takes the operation's initial carry; every later bit chains the stored carry.
    assign cin_from_carry = (idx != '0);

    always_comb begin
        sa        = 1'b0;
        sb        = 1'b0;
        op        = SOP_AND;
        cin_first = 1'b0;
        is_arith  = 1'b0;
        is_slt    = 1'b0;
        case (ctl)
            ALU_AND: op = SOP_AND;
            ALU_OR:  op = SOP_OR;
            ALU_NOR: begin
                sa = 1'b1;
                sb = 1'b1;
                op = SOP_AND;
            end
            ALU_ADD: begin
                op       = SOP_SUM;
                is_arith = 1'b1;
            end
            ALU_SUB: begin
                sb        = 1'b1;
                op        = SOP_SUM;
                cin_first = 1'b1;
                is_arith  = 1'b1;
            end
            ALU_SLT: begin
                sb        = 1'b1;
                op        = SOP_SUM;
                cin_first = 1'b1;
                is_slt    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: steps one external 1-bit slice LSB-first and assembles
// the result word and flags behind a valid/ready handshake.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a request
//   RUN   | one operand bit per clock through the slice, carry chained
//   SET   | SLT only: push the captured less-than bit through the slice as bit 0
//   DONE  | out_valid high, result and flags held until out_ready
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             slc_a,
    output logic             slc_b,
    output logic             slc_sm,
    output logic             slc_sa,
    output logic             slc_sb,
    output logic             slc_cin,
    output logic [1:0]       slc_op,
    input  logic             slc_result,
    input  logic             slc_cout
);

    localparam int               IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [3:0]       ctl_q;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             set_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    logic       dec_sa;
    logic       dec_sb;
    logic [1:0] dec_op;
    logic       dec_cin_from_carry;
    logic       dec_cin_first;
    logic       dec_is_arith;
    logic       dec_is_slt;

    alu_slice_decode #(
        .IDX_W (IDX_W)
    ) u_decode (
        .ctl            (ctl_q),
        .idx            (idx),
        .sa             (dec_sa),
        .sb             (dec_sb),
        .op             (dec_op),
        .cin_from_carry (dec_cin_from_carry),
        .cin_first      (dec_cin_first),
        .is_arith       (dec_is_arith),
        .is_slt         (dec_is_slt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ctl_supported(alu_ctl) ? ST_RUN : ST_DONE;
            ST_RUN:  if (idx == LAST) state_nxt = dec_is_slt ? ST_SET : ST_DONE;
            ST_SET:  state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        slc_a     = 1'b0;
        slc_b     = 1'b0;
        slc_sm    = 1'b0;
        slc_sa    = 1'b0;
        slc_sb    = 1'b0;
        slc_cin   = 1'b0;
        slc_op    = SOP_AND;
        case (state)
            ST_RUN: begin
                slc_a   = opa_q[idx];
                slc_b   = opb_q[idx];
                slc_sa  = dec_sa;
                slc_sb  = dec_sb;
                slc_op  = dec_op;
                slc_cin = dec_cin_from_carry ? carry : dec_cin_first;
            end
            ST_SET: begin
                slc_a  = opa_q[0];
                slc_b  = opb_q[0];
                slc_sm = set_q;
                slc_op = SOP_SM;
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_nxt      = acc;
        acc_nxt[idx] = slc_result;
    end

    // The working word lives in acc; result and flags only change on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_q     <= '0;
            opb_q     <= '0;
            ctl_q     <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            set_q     <= 1'b0;
            acc       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        opa_q <= opa;
                        opb_q <= opb;
                        ctl_q <= alu_ctl;
                        idx   <= '0;
                        carry <= 1'b0;
                        acc   <= '0;
                        if (!ctl_supported(alu_ctl)) begin
                            result    <= '0;
                            zero      <= 1'b1;
                            carry_out <= 1'b0;
                            overflow  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    carry <= slc_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        if (dec_is_slt) begin
                            // Signed less-than: MSB of the difference corrected by overflow.
                            set_q <= slc_result ^ slc_cin ^ slc_cout;
                        end else begin
                            result    <= acc_nxt;
                            zero      <= (acc_nxt == '0);
                            carry_out <= dec_is_arith & slc_cout;
                            overflow  <= dec_is_arith & (slc_cin ^ slc_cout);
                        end
                    end
                end
                ST_SET: begin
                    result    <= {{(WIDTH-1){1'b0}}, slc_result};
                    zero      <= ~slc_result;
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
